// File: rtl/final2_soc_sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : final2_soc_sysid_pkg
// Brief    : Shared types and constants for the sysid boot checker.
// Revision : 1.0
// ============================================================================
package final2_soc_sysid_pkg;

    typedef logic [31:0] sysid_word_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ID  = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_RD_TS  = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6
    } sysid_state_t;

endpackage
`default_nettype wire

// File: rtl/final2_soc_sysid_rd_port.sv
`default_nettype none
// ============================================================================
// Module   : final2_soc_sysid_rd_port
// Brief    : One Avalon-MM read: strobe, stall/timeout count, latency count.
// Revision : 1.0
// ============================================================================
module final2_soc_sysid_rd_port
    import final2_soc_sysid_pkg::*;
#(
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_rd_active,
    input  logic i_lat_active,
    input  logic i_addr,
    input  logic i_waitrequest,
    output logic o_read,
    output logic o_address,
    output logic o_accept,
    output logic o_timeout,
    output logic o_capture
);

    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]  c_LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    logic [15:0] r_wait_cnt;
    logic [1:0]  r_lat_cnt;
    logic        w_lat_last;

    assign o_read     = i_rd_active;
    assign o_address  = i_rd_active ? i_addr : SYSID_ADDR_ID;
    assign o_accept   = i_rd_active & ~i_waitrequest;
    assign o_timeout  = i_rd_active & i_waitrequest & (r_wait_cnt == c_TMO_LAST);
    assign w_lat_last = i_lat_active & (r_lat_cnt == c_LAT_LAST);
    // With zero latency the data is already valid in the acceptance cycle.
    assign o_capture  = (READ_LATENCY == 0) ? o_accept : w_lat_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_lat_cnt  <= '0;
        end else begin
            if (i_rd_active & i_waitrequest) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (i_lat_active & ~w_lat_last) begin
                r_lat_cnt <= r_lat_cnt + 2'd1;
            end else begin
                r_lat_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/final2_soc_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : final2_soc_sysid_checker
// Brief    : Reads sysid ID/timestamp words and verifies the hardware image.
// Revision : 1.0
// ============================================================================
module final2_soc_sysid_checker
    import final2_soc_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1512003615,
    parameter int          READ_LATENCY = 0,
    parameter int          MAX_RETRY    = 2,
    parameter int          TIMEOUT      = 255,
    parameter int          AUTO_START   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retries
);

    localparam logic [3:0] c_MAX_RETRY = 4'(MAX_RETRY);

    sysid_state_t r_state;
    sysid_state_t w_state_nx;
    sysid_word_t  r_id;
    sysid_word_t  r_ts;
    logic [3:0]   r_retries;
    logic         r_auto_pend;
    logic         r_busy;
    logic         r_done;
    logic         r_pass;
    logic         r_fail;
    logic         r_timeout;
    logic         w_rd_active;
    logic         w_lat_active;
    logic         w_addr;
    logic         w_is_ts;
    logic         w_accept;
    logic         w_tmo;
    logic         w_capture;
    logic         w_match;

    final2_soc_sysid_rd_port #(
        .READ_LATENCY (READ_LATENCY),
        .TIMEOUT      (TIMEOUT)
    ) u_rd_port (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_rd_active   (w_rd_active),
        .i_lat_active  (w_lat_active),
        .i_addr        (w_addr),
        .i_waitrequest (m_waitrequest),
        .o_read        (m_read),
        .o_address     (m_address),
        .o_accept      (w_accept),
        .o_timeout     (w_tmo),
        .o_capture     (w_capture)
    );

    assign w_match = (r_id == EXPECTED_ID) && (r_ts == EXPECTED_TS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:   if (start || r_auto_pend) w_state_nx = ST_RD_ID;
            ST_RD_ID:  if (w_accept) w_state_nx = (READ_LATENCY == 0) ? ST_RD_TS : ST_LAT_ID;
                       else if (w_tmo) w_state_nx = ST_DONE;
            ST_LAT_ID: if (w_capture) w_state_nx = ST_RD_TS;
            ST_RD_TS:  if (w_accept) w_state_nx = (READ_LATENCY == 0) ? ST_CHECK : ST_LAT_TS;
                       else if (w_tmo) w_state_nx = ST_DONE;
            ST_LAT_TS: if (w_capture) w_state_nx = ST_CHECK;
            ST_CHECK:  w_state_nx = (w_match || (r_retries >= c_MAX_RETRY)) ? ST_DONE : ST_RD_ID;
            ST_DONE:   w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_active  = (r_state == ST_RD_ID)  || (r_state == ST_RD_TS);
        w_lat_active = (r_state == ST_LAT_ID) || (r_state == ST_LAT_TS);
        w_is_ts      = (r_state == ST_RD_TS)  || (r_state == ST_LAT_TS);
        w_addr       = w_is_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_auto_pend <= (AUTO_START != 0);
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_retries   <= '0;
            r_id        <= '0;
            r_ts        <= '0;
        end else begin
            // A start coinciding with the auto launch is absorbed by the same launch.
            r_auto_pend <= 1'b0;
            r_busy      <= (w_state_nx != ST_IDLE);
            r_done      <= (w_state_nx == ST_DONE);
            if ((r_state == ST_IDLE) && (w_state_nx == ST_RD_ID)) begin
                r_pass    <= 1'b0;
                r_fail    <= 1'b0;
                r_timeout <= 1'b0;
                r_retries <= '0;
            end
            if (w_capture) begin
                if (w_is_ts) begin
                    r_ts <= m_readdata;
                end else begin
                    r_id <= m_readdata;
                end
            end
            if (w_tmo) begin
                r_timeout <= 1'b1;
                r_fail    <= 1'b1;
            end
            if (r_state == ST_CHECK) begin
                if (w_match) begin
                    r_pass <= 1'b1;
                end else if (r_retries < c_MAX_RETRY) begin
                    r_retries <= r_retries + 4'd1;
                end else begin
                    r_fail <= 1'b1;
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign timeout  = r_timeout;
    assign retries  = r_retries;
    assign id_value = r_id;
    assign ts_value = r_ts;

endmodule
`default_nettype wire

// File: tb/tb_final2_soc_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_final2_soc_sysid_checker
// Brief    : Scoreboard bench; two checker instances (latency 0 and 2).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_final2_soc_sysid_checker;

    localparam logic [31:0] c_EXP_ID    = 32'd0;
    localparam logic [31:0] c_EXP_TS    = 32'd1512003615;
    localparam int          c_MAX_RETRY = 2;
    localparam int          c_TIMEOUT   = 8;
    localparam logic [31:0] c_GARBAGE   = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        e_pass;
        logic        e_fail;
        logic        e_tmo;
        logic [3:0]  e_retries;
        logic [31:0] e_id;
        logic [31:0] e_ts;
        logic [15:0] e_cycles;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  m_read, m_address, waitreq, busy_v, done_v, pass_v, fail_v, tmo_v;
    logic [31:0] rdata [2];
    logic [31:0] id_v  [2];
    logic [31:0] ts_v  [2];
    logic [3:0]  retr  [2];

    int          sc_stall;
    logic [2:0]  sc_bad0, sc_bad1;
    logic [31:0] sc_bv0, sc_bv1;
    logic        sc_stuck;

    int          checks, errors;
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] last_id [2];
    logic [31:0] last_ts [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] word_for(input logic addr, input int p);
        int q;
        q = (p > 2) ? 2 : ((p < 0) ? 0 : p);
        if (!addr) return sc_bad0[q] ? sc_bv0 : c_EXP_ID;
        return sc_bad1[q] ? sc_bv1 : c_EXP_TS;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%08h, expected 0x%08h", name, inst, act, exp);
        end
    endtask

    // Reference: each pass costs two reads (stall + accept + latency) plus CHECK; DONE adds one.
    task automatic model(input int lat, input int inst, output exp_t e);
        e = '0;
        e.e_id = last_id[inst];
        e.e_ts = last_ts[inst];
        if (sc_stuck) begin
            e.e_fail   = 1'b1;
            e.e_tmo    = 1'b1;
            e.e_cycles = 16'(c_TIMEOUT + 1);
        end else begin
            int cyc;
            cyc = 1;
            for (int p = 0; p <= c_MAX_RETRY; p++) begin
                e.e_id      = word_for(1'b0, p);
                e.e_ts      = word_for(1'b1, p);
                e.e_retries = 4'(p);
                cyc += 2 * (sc_stall + 1 + lat) + 1;
                if (e.e_id == c_EXP_ID && e.e_ts == c_EXP_TS) begin
                    e.e_pass = 1'b1;
                    break;
                end
            end
            if (!e.e_pass) e.e_fail = 1'b1;
            e.e_cycles = 16'(cyc);
        end
        last_id[inst] = e.e_id;
        last_ts[inst] = e.e_ts;
    endtask

    task automatic check_done(input int inst, input int cyc);
        exp_t e;
        if ((inst == 0 && sb0.size() == 0) || (inst == 1 && sb1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done inst%0d: got a done pulse, expected none", inst);
            return;
        end
        if (inst == 0) e = sb0.pop_front();
        else           e = sb1.pop_front();
        chk("done_pass",    inst, 32'(pass_v[inst]), 32'(e.e_pass));
        chk("done_fail",    inst, 32'(fail_v[inst]), 32'(e.e_fail));
        chk("done_timeout", inst, 32'(tmo_v[inst]),  32'(e.e_tmo));
        chk("done_retries", inst, 32'(retr[inst]),   32'(e.e_retries));
        chk("done_id",      inst, id_v[inst],        e.e_id);
        chk("done_ts",      inst, ts_v[inst],        e.e_ts);
        chk("done_cycles",  inst, 32'(cyc),          32'(e.e_cycles));
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int LAT  = (gi == 0) ? 0 : 2;
        localparam int PIDX = (LAT == 0) ? 0 : LAT - 1;

        int          wc;
        int          n0;
        int          bcnt;
        logic [3:0]  pv;
        logic [31:0] pd [4];
        logic [31:0] word_now;

        final2_soc_sysid_checker #(
            .EXPECTED_ID  (c_EXP_ID),
            .EXPECTED_TS  (c_EXP_TS),
            .READ_LATENCY (LAT),
            .MAX_RETRY    (c_MAX_RETRY),
            .TIMEOUT      (c_TIMEOUT),
            .AUTO_START   (1)
        ) u_dut (
            .clock         (clk),
            .reset_n       (rst_n),
            .start         (start),
            .m_address     (m_address[gi]),
            .m_read        (m_read[gi]),
            .m_waitrequest (waitreq[gi]),
            .m_readdata    (rdata[gi]),
            .busy          (busy_v[gi]),
            .done          (done_v[gi]),
            .pass          (pass_v[gi]),
            .fail          (fail_v[gi]),
            .timeout       (tmo_v[gi]),
            .id_value      (id_v[gi]),
            .ts_value      (ts_v[gi]),
            .retries       (retr[gi])
        );

        // Slave model: stalls each read sc_stall cycles, data valid only in its latency slot.
        always_comb begin
            word_now = word_for(m_address[gi], m_address[gi] ? n0 - 1 : n0);
        end
        assign waitreq[gi] = sc_stuck || (wc < sc_stall);
        assign rdata[gi]   = (LAT == 0) ? ((m_read[gi] && !waitreq[gi]) ? word_now : c_GARBAGE)
                                        : (pv[PIDX] ? pd[PIDX] : c_GARBAGE);

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wc <= 0;
                n0 <= 0;
                pv <= '0;
            end else begin
                if (m_read[gi] && waitreq[gi]) wc <= wc + 1;
                else                           wc <= 0;
                if (!busy_v[gi])                                         n0 <= 0;
                else if (m_read[gi] && !waitreq[gi] && !m_address[gi]) n0 <= n0 + 1;
                pv    <= {pv[2:0], m_read[gi] && !waitreq[gi]};
                pd[0] <= word_now;
                pd[1] <= pd[0];
                pd[2] <= pd[1];
                pd[3] <= pd[2];
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                bcnt <= 0;
            end else if (done_v[gi]) begin
                check_done(gi, bcnt + 1);
                bcnt <= 0;
            end else if (busy_v[gi]) begin
                bcnt <= bcnt + 1;
            end
        end
    end

    task automatic push_expect();
        exp_t e;
        model(0, 0, e);
        sb0.push_back(e);
        model(2, 1, e);
        sb1.push_back(e);
    endtask

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int n = 0; n < 1000 && quiet < 4; n++) begin
            @(negedge clk);
            if (busy_v == 2'b00) quiet++;
            else                 quiet = 0;
        end
        if (quiet < 4) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b, expected 00", busy_v);
        end
    endtask

    task automatic run_check(input bit pulse_extra);
        push_expect();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (pulse_extra) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ctrl", i, 32'({m_read[i], m_address[i], busy_v[i], done_v[i],
                                    pass_v[i], fail_v[i], tmo_v[i]}), 32'd0);
            chk("rst_retries", i, 32'(retr[i]), 32'd0);
            chk("rst_id", i, id_v[i], 32'd0);
            chk("rst_ts", i, ts_v[i], 32'd0);
        end
    endtask

    task automatic clear_scenario();
        sc_stall = 0;
        sc_bad0  = 3'b000;
        sc_bad1  = 3'b000;
        sc_bv0   = 32'h0;
        sc_bv1   = 32'h0;
        sc_stuck = 1'b0;
    endtask

    initial begin
        exp_t e;
        bit   hit;
        checks = 0;
        errors = 0;
        clear_scenario();
        for (int i = 0; i < 2; i++) begin
            last_id[i] = '0;
            last_ts[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1 check_reset_vals();
        push_expect();
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle();

        sc_stall = 3;
        run_check(1'b1);

        clear_scenario();
        sc_bad1 = 3'b111;
        sc_bv1  = 32'h1234_5678;
        run_check(1'b0);

        clear_scenario();
        sc_bad0 = 3'b001;
        sc_bv0  = 32'hCAFE_0001;
        run_check(1'b0);

        clear_scenario();
        sc_stuck = 1'b1;
        run_check(1'b0);

        for (int n = 0; n < 24; n++) begin
            clear_scenario();
            sc_stall = $urandom_range(0, 3);
            sc_bad0  = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            sc_bad1  = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            sc_bv0   = $urandom | 32'h1;
            sc_bv1   = $urandom;
            if (sc_bv1 == c_EXP_TS) sc_bv1 = ~sc_bv1;
            sc_stuck = ($urandom_range(0, 9) == 0);
            run_check(1'($urandom_range(0, 1)));
        end

        // Abort instance 1 in LAT_TS; instance 0 finishes before the reset lands.
        clear_scenario();
        model(0, 0, e);
        sb0.push_back(e);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 50 && !hit; n++) begin
            if (m_read[1] && m_address[1] && !waitreq[1]) hit = 1'b1;
            else @(negedge clk);
        end
        chk("reach_rd_ts", 1, 32'(hit), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_vals();
        for (int i = 0; i < 2; i++) begin
            last_id[i] = '0;
            last_ts[i] = '0;
        end
        repeat (2) @(posedge clk);
        push_expect();
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle();

        chk("sb_empty", 0, 32'(sb0.size()), 32'd0);
        chk("sb_empty", 1, 32'(sb1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
